// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
//   Shared definitions for the RTC multiplexed AD-bus sequencers (time
//   read-back and time write).
//   Contents: RTC register addresses, the idle bus value, the per-slot
//   strobe timing points and the slot enumeration with its address map.
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_SEG      = 8'h21;
  localparam logic [7:0] ADDR_CTRL     = 8'h00;  // used by the writer only
  localparam logic [7:0] ADDR_TRANSFER = 8'hf1;  // used by the writer only

  localparam logic [7:0] AD_IDLE = 8'hff;

  // Slot timing points: the action is registered on the edge where the
  // slot counter equals the value.
  localparam int         CONT_W     = 6;
  localparam logic [5:0] T_AD_LO    = 6'd1;
  localparam logic [5:0] T_CS_LO    = 6'd2;
  localparam logic [5:0] T_WR_LO    = 6'd3;
  localparam logic [5:0] T_ADDR     = 6'd4;
  localparam logic [5:0] T_WR_HI    = 6'd9;
  localparam logic [5:0] T_CS_HI    = 6'd10;
  localparam logic [5:0] T_AD_HI    = 6'd11;
  localparam logic [5:0] T_REL      = 6'd13;
  localparam logic [5:0] T_CS2_LO   = 6'd21;
  localparam logic [5:0] T_RD_LO    = 6'd22;
  localparam logic [5:0] T_SAMPLE   = 6'd27;
  localparam logic [5:0] T_RD_HI    = 6'd28;
  localparam logic [5:0] T_CS2_HI   = 6'd29;
  localparam logic [5:0] T_SLOT_END = 6'd40;

  typedef enum logic [1:0] {
    SLOT_HORA = 2'd0,
    SLOT_MIN  = 2'd1,
    SLOT_SEG  = 2'd2
  } slot_e;

  function automatic logic [7:0] slot_addr(input slot_e s);
    case (s)
      SLOT_HORA: slot_addr = ADDR_HORA;
      SLOT_MIN:  slot_addr = ADDR_MIN;
      default:   slot_addr = ADDR_SEG;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle
//   Runs one address-then-read slot on the RTC AD bus while en_i is high.
//   The slot counter restarts at 0 whenever en_i is low, so each enable
//   period begins a fresh slot; back-to-back slots wrap at T_SLOT_END.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   en_i           run slots; low forces the bus idle
//   addr_i         register address driven in the address phase
//   ad_in_i        AD bus value from the pad
//   ad_out_o       AD bus drive value (AD_IDLE when not driving)
//   bus_oe_o       drive enable for ad_out_o
//   ad_o/cs_o/wr_o/rd_o  active-low strobes
//   byte_o         byte captured in the read phase
//   slot_done_o    high during the last cycle of a slot
module rtc_bus_cycle
  import rtc_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] ad_in_i,
  output logic [7:0] ad_out_o,
  output logic       bus_oe_o,
  output logic       ad_o,
  output logic       cs_o,
  output logic       wr_o,
  output logic       rd_o,
  output logic [7:0] byte_o,
  output logic       slot_done_o
);

  logic [CONT_W-1:0] cont_q;
  logic [7:0]        ad_out_q;
  logic              bus_oe_q, ad_q, cs_q, wr_q, rd_q;
  logic [7:0]        byte_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q   <= '0;
      ad_out_q <= AD_IDLE;
      bus_oe_q <= 1'b0;
      ad_q     <= 1'b1;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      rd_q     <= 1'b1;
      byte_q   <= '0;
    end else if (!en_i) begin
      cont_q   <= '0;
      ad_out_q <= AD_IDLE;
      bus_oe_q <= 1'b0;
      ad_q     <= 1'b1;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      rd_q     <= 1'b1;
    end else begin
      cont_q <= (cont_q == T_SLOT_END) ? '0 : cont_q + 1'b1;
      case (cont_q)
        6'd0: begin
          ad_q <= 1'b1;
          cs_q <= 1'b1;
          wr_q <= 1'b1;
          rd_q <= 1'b1;
        end
        T_AD_LO:  ad_q <= 1'b0;
        T_CS_LO:  cs_q <= 1'b0;
        T_WR_LO:  wr_q <= 1'b0;
        T_ADDR: begin
          ad_out_q <= addr_i;
          bus_oe_q <= 1'b1;
        end
        T_WR_HI:  wr_q <= 1'b1;
        T_CS_HI:  cs_q <= 1'b1;
        T_AD_HI:  ad_q <= 1'b1;
        // Release the bus well before rd falls so the RTC can turn it around.
        T_REL: begin
          ad_out_q <= AD_IDLE;
          bus_oe_q <= 1'b0;
        end
        T_CS2_LO: cs_q <= 1'b0;
        T_RD_LO:  rd_q <= 1'b0;
        T_SAMPLE: byte_q <= ad_in_i;
        T_RD_HI:  rd_q <= 1'b1;
        T_CS2_HI: cs_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ad_out_o    = ad_out_q;
  assign bus_oe_o    = bus_oe_q;
  assign ad_o        = ad_q;
  assign cs_o        = cs_q;
  assign wr_o        = wr_q;
  assign rd_o        = rd_q;
  assign byte_o      = byte_q;
  assign slot_done_o = en_i && (cont_q == T_SLOT_END);

endmodule

// File: rtl/lectura_hora.sv
// lectura_hora
//   Reads hour, minute and second from the RTC over the multiplexed AD bus
//   on a rising edge of start, then updates hora/AmPm/min/seg together and
//   pulses done.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               read request (rising edge)
//   ADin / ADout        AD bus in / drive value (8'hff when not driving)
//   bus_oe              top level drives ADout onto the bus
//   ad, cs, wr, rd      active-low RTC strobes
//   hora, AmPm          hour BCD and AM/PM bit of the hour byte
//   min, seg            minute and second BCD
//   busy, done          sequence in progress / one-cycle update pulse
//
// slot      | meaning
// SLOT_HORA | reading hour register (0x23)
// SLOT_MIN  | reading minute register (0x22)
// SLOT_SEG  | reading second register (0x21), outputs update at its end
module lectura_hora
  import rtc_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ADin,
  output logic [7:0] ADout,
  output logic       bus_oe,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [6:0] hora,
  output logic       AmPm,
  output logic [7:0] min,
  output logic [7:0] seg,
  output logic       busy,
  output logic       done
);

  slot_e      slot_q;
  logic       busy_q, done_q, start_q;
  logic [7:0] shadow_h_q, shadow_m_q;
  logic [6:0] hora_q;
  logic       ampm_q;
  logic [7:0] min_q, seg_q;

  logic [7:0] byte_rd;
  logic       slot_done;

  rtc_bus_cycle u_cycle (
    .clock       (clock),
    .reset       (reset),
    .en_i        (busy_q),
    .addr_i      (slot_addr(slot_q)),
    .ad_in_i     (ADin),
    .ad_out_o    (ADout),
    .bus_oe_o    (bus_oe),
    .ad_o        (ad),
    .cs_o        (cs),
    .wr_o        (wr),
    .rd_o        (rd),
    .byte_o      (byte_rd),
    .slot_done_o (slot_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q     <= SLOT_HORA;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      shadow_h_q <= '0;
      shadow_m_q <= '0;
      hora_q     <= '0;
      ampm_q     <= 1'b0;
      min_q      <= '0;
      seg_q      <= '0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      if (!busy_q) begin
        if (start && !start_q) begin
          busy_q <= 1'b1;
          slot_q <= SLOT_HORA;
        end
      end else if (slot_done) begin
        case (slot_q)
          SLOT_HORA: begin
            shadow_h_q <= byte_rd;
            slot_q     <= SLOT_MIN;
          end
          SLOT_MIN: begin
            shadow_m_q <= byte_rd;
            slot_q     <= SLOT_SEG;
          end
          default: begin
            // The second byte is still in the cycle engine's capture
            // register, so all four outputs change on this one edge.
            hora_q <= shadow_h_q[6:0];
            ampm_q <= shadow_h_q[7];
            min_q  <= shadow_m_q;
            seg_q  <= byte_rd;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            slot_q <= SLOT_HORA;
          end
        endcase
      end
    end
  end

  assign hora = hora_q;
  assign AmPm = ampm_q;
  assign min  = min_q;
  assign seg  = seg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_lectura_hora.sv
module tb_lectura_hora;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ADin;
  logic [7:0] ADout;
  logic       bus_oe, ad, cs, wr, rd;
  logic [6:0] hora;
  logic       AmPm;
  logic [7:0] min, seg;
  logic       busy, done;

  int compared   = 0;
  int mismatched = 0;

  lectura_hora dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ADin   (ADin),
    .ADout  (ADout),
    .bus_oe (bus_oe),
    .ad     (ad),
    .cs     (cs),
    .wr     (wr),
    .rd     (rd),
    .hora   (hora),
    .AmPm   (AmPm),
    .min    (min),
    .seg    (seg),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  // RTC model: latches the address during the address phase and returns
  // the register only while rd and cs are both low; 8'h00 otherwise.
  logic [7:0] mem_h, mem_m, mem_s;
  logic [7:0] lat_addr = 8'h00;

  always @(posedge clock) if (bus_oe && !ad) lat_addr <= ADout;

  always_comb begin
    ADin = 8'h00;
    if (!rd && !cs) begin
      case (lat_addr)
        8'h23:   ADin = mem_h;
        8'h22:   ADin = mem_m;
        8'h21:   ADin = mem_s;
        default: ADin = 8'h00;
      endcase
    end
  end

  // Bus protocol monitor.
  int viol_rw = 0, viol_oe = 0, viol_addr = 0, done_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (!rd && !wr) viol_rw++;
      if (!rd && bus_oe) viol_oe++;
      if (ADout != 8'hff && !bus_oe) viol_addr++;
      if (bus_oe && !(ADout inside {8'h21, 8'h22, 8'h23})) viol_addr++;
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_adout"}, ADout, 8'hff);
    chk({tag, "_oe"}, bus_oe, 1'b0);
    chk({tag, "_strobes"}, {ad, cs, wr, rd}, 4'hf);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mem_h = 8'h92; mem_m = 8'h45; mem_s = 8'h30;

    // Reset state
    tick(3);
    chk_idle_bus("rst");
    chk("rst_hora", hora, 7'h00);
    chk("rst_ampm", AmPm, 1'b0);
    chk("rst_min", min, 8'h00);
    chk("rst_seg", seg, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    tick(2);

    // Run 1 (N), with an ignored start edge at N+50
    start = 1'b1;                   // N
    tick(1); start = 1'b0;          // N+1
    chk("r1_busy_n1", busy, 1'b1);
    tick(49);                       // N+50
    start = 1'b1;
    tick(1); start = 1'b0;          // N+51
    tick(72);                       // N+123
    chk("r1_busy_n123", busy, 1'b1);
    chk("r1_done_n123", done, 1'b0);
    chk("r1_hora_hold", hora, 7'h00);
    tick(1);                        // N+124
    chk("r1_done", done, 1'b1);
    chk("r1_busy_end", busy, 1'b0);
    chk("r1_hora", hora, 7'h12);
    chk("r1_ampm", AmPm, 1'b1);
    chk("r1_min", min, 8'h45);
    chk("r1_seg", seg, 8'h30);
    tick(1);                        // N+125
    chk("r1_done_pulse", done, 1'b0);
    chk_idle_bus("r1_idle");

    // Run 2 started at N+125, done expected at N+249
    mem_h = 8'h11; mem_m = 8'h59; mem_s = 8'h07;
    start = 1'b1;
    tick(1); start = 1'b0;
    tick(122);                      // N+248
    chk("r2_done_early", done, 1'b0);
    chk("r1_single_done", done_cnt, 1);
    tick(1);                        // N+249
    chk("r2_done", done, 1'b1);
    chk("r2_hora", hora, 7'h11);
    chk("r2_ampm", AmPm, 1'b0);
    chk("r2_min", min, 8'h59);
    chk("r2_seg", seg, 8'h07);
    tick(2);

    // Reset in the middle of the minute slot
    mem_h = 8'h83; mem_m = 8'h01; mem_s = 8'h02;
    start = 1'b1;                   // M
    tick(1); start = 1'b0;
    tick(59);                       // M+60
    chk("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick(1);                        // M+61
    chk_idle_bus("mid");
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    reset = 1'b0;
    tick(130);
    chk("mid_no_done", done_cnt, 2);
    chk("mid_busy_later", busy, 1'b0);

    // Start held high for 300 cycles: exactly one sequence
    start = 1'b1;                   // S
    tick(124);                      // S+124
    chk("held_done", done, 1'b1);
    chk("held_hora", hora, 7'h03);
    chk("held_ampm", AmPm, 1'b1);
    chk("held_min", min, 8'h01);
    chk("held_seg", seg, 8'h02);
    tick(176);                      // S+300
    start = 1'b0;
    tick(5);
    chk("held_one_seq", done_cnt, 3);
    chk("held_busy", busy, 1'b0);

    // Protocol monitor totals
    chk("proto_rd_wr", viol_rw, 0);
    chk("proto_oe_rd", viol_oe, 0);
    chk("proto_addr", viol_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
